// File: rtl/mult_div_unit_pkg.sv
// Shared MADop encodings and default latencies for the decoder and the multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MAD_DEFAULT  = 3'd0,
    MAD_MULT     = 3'd1,
    MAD_MULTU    = 3'd2,
    MAD_DIV      = 3'd3,
    MAD_DIVU     = 3'd4,
    MAD_HI_WRITE = 3'd5,
    MAD_LO_WRITE = 3'd6,
    MAD_MADD     = 3'd7
  } mad_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage handshake between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  MADop;
  logic [31:0] RS_Data;
  logic [31:0] RT_Data;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MADop, RS_Data, RT_Data, input Busy, HI, LO);
  modport slave  (input Start, MADop, RS_Data, RT_Data, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit_arith.sv
// Combinational result generator for the multiply/divide unit.
// Build option MDU_MADD_EN makes MADop=7 a signed multiply-accumulate into {HI,LO}.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        accept,
  output logic        is_div,
  output logic        commit
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic        [31:0] dvs_u, quo_u, rem_u;
  logic               div_zero;

  assign prod_s   = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u   = {32'd0, rs} * {32'd0, rt};
  assign div_zero = (rt == 32'd0);

  // 33-bit signed divide keeps -2^31 / -1 well defined; divisor forced to 1 on zero to avoid X.
  assign dvd_s = $signed({rs[31], rs});
  assign dvs_s = div_zero ? 33'sd1 : $signed({rt[31], rt});
  assign quo_s = dvd_s / dvs_s;
  assign rem_s = dvd_s % dvs_s;
  assign dvs_u = div_zero ? 32'd1 : rt;
  assign quo_u = rs / dvs_u;
  assign rem_u = rs % dvs_u;

`ifdef MDU_MADD_EN
  logic [63:0] madd_sum;
  assign madd_sum = {hi, lo} + $unsigned(prod_s);
`endif

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    accept = 1'b0;
    is_div = 1'b0;
    commit = 1'b0;
    case (mad_op_e'(op))
      MAD_MULT: begin
        accept = 1'b1;
        commit = 1'b1;
        {res_hi, res_lo} = $unsigned(prod_s);
      end
      MAD_MULTU: begin
        accept = 1'b1;
        commit = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      MAD_DIV: begin
        accept = 1'b1;
        is_div = 1'b1;
        commit = !div_zero;
        res_lo = quo_s[31:0];
        res_hi = rem_s[31:0];
      end
      MAD_DIVU: begin
        accept = 1'b1;
        is_div = 1'b1;
        commit = !div_zero;
        res_lo = quo_u;
        res_hi = rem_u;
      end
`ifdef MDU_MADD_EN
      MAD_MADD: begin
        accept = 1'b1;
        commit = 1'b1;
        {res_hi, res_lo} = madd_sum;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO; results land when Busy falls.
// MADD support is selected by the MDU_MADD_EN build macro (see mdu_arith).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_reg;
  logic [CW-1:0] counter_reg;
  logic         busy_reg;
  logic [31:0]  hi_reg, lo_reg;
  logic [31:0]  pend_hi_reg, pend_lo_reg;
  logic         pend_commit_reg;

  logic [31:0]  res_hi, res_lo;
  logic         accept, is_div, commit;

  mdu_arith u_arith (
    .op     (bus.MADop),
    .rs     (bus.RS_Data),
    .rt     (bus.RT_Data),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .accept (accept),
    .is_div (is_div),
    .commit (commit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      counter_reg     <= '0;
      busy_reg        <= 1'b0;
      hi_reg          <= 32'd0;
      lo_reg          <= 32'd0;
      pend_hi_reg     <= 32'd0;
      pend_lo_reg     <= 32'd0;
      pend_commit_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.Start && accept) begin
            pend_hi_reg     <= res_hi;
            pend_lo_reg     <= res_lo;
            pend_commit_reg <= commit;
            counter_reg     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_reg        <= 1'b1;
            state_reg       <= RUN;
          end else if (!bus.Start && bus.MADop == MAD_HI_WRITE) begin
            hi_reg <= bus.RS_Data;
          end else if (!bus.Start && bus.MADop == MAD_LO_WRITE) begin
            lo_reg <= bus.RS_Data;
          end
        end
        RUN: begin
          // Every input is ignored while running; only the countdown advances.
          if (counter_reg == CW'(1)) begin
            counter_reg <= '0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
            if (pend_commit_reg) begin
              hi_reg <= pend_hi_reg;
              lo_reg <= pend_lo_reg;
            end
          end else begin
            counter_reg <= counter_reg - CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_reg;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, corner sequences and a randomized model comparison.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if mdu_if ();
  mult_div_unit dut (.clk(clk), .reset(reset), .bus(mdu_if));

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_len;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour from the arithmetic rules; also returns the expected Busy length.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                   inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
    logic signed [63:0] a, b, q, r, p;
    logic [63:0] u;
    cyc = 0;
    a = 64'($signed(rs));
    b = 64'($signed(rt));
    p = a * b;
    case (op)
      3'd1: begin {hi, lo} = p; cyc = 5; end
      3'd2: begin u = 64'(rs) * 64'(rt); {hi, lo} = u; cyc = 5; end
      3'd3: begin
        cyc = 10;
        if (rt != 0) begin q = a / b; r = a % b; lo = q[31:0]; hi = r[31:0]; end
      end
      3'd4: begin
        cyc = 10;
        if (rt != 0) begin lo = rs / rt; hi = rs % rt; end
      end
`ifdef MDU_MADD_EN
      3'd7: begin {hi, lo} = {hi, lo} + p; cyc = 5; end
`endif
      default: ;
    endcase
  endfunction

  // Called at a negedge; drives one Start cycle, measures Busy, checks committed HI/LO.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_len,
                        input string name);
    int len;
    mdu_if.Start = 1'b1;
    mdu_if.MADop = op;
    mdu_if.RS_Data = rs;
    mdu_if.RT_Data = rt;
    @(negedge clk);
    mdu_if.Start = 1'b0;
    mdu_if.MADop = 3'd0;
    len = 0;
    while (mdu_if.Busy && len < 40) begin
      len++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, 32'(len), 32'(exp_len));
    check({name, "_hi"}, mdu_if.HI, exp_hi);
    check({name, "_lo"}, mdu_if.LO, exp_lo);
    $display("[TB] %s op=%0d rs=%08h rt=%08h busy=%0d hi=%08h lo=%08h", name, op, rs, rt, len,
             mdu_if.HI, mdu_if.LO);
  endtask

  task automatic write_reg(input logic [2:0] op, input logic [31:0] val, input string name);
    mdu_if.Start = 1'b0;
    mdu_if.MADop = op;
    mdu_if.RS_Data = val;
    @(negedge clk);
    mdu_if.MADop = 3'd0;
    if (op == 3'd5) m_hi = val; else m_lo = val;
    check({name, "_busy"}, 32'(mdu_if.Busy), 32'd0);
    check({name, "_hi"}, mdu_if.HI, m_hi);
    check({name, "_lo"}, mdu_if.LO, m_lo);
    $display("[TB] %s op=%0d val=%08h hi=%08h lo=%08h", name, op, val, mdu_if.HI, mdu_if.LO);
  endtask

  initial begin
    int len, cyc;
    logic [2:0] op;
    logic [31:0] rs, rt;

    vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult_neg"};
    vecs[1] = '{3'd2, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 5, "multu"};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"};
    vecs[3] = '{3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu"};
    vecs[4] = '{3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, "div_negdivisor"};

    mdu_if.Start = 1'b0;
    mdu_if.MADop = 3'd0;
    mdu_if.RS_Data = 32'd0;
    mdu_if.RT_Data = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(mdu_if.Busy), 32'd0);
    check("reset_hi", mdu_if.HI, 32'd0);
    check("reset_lo", mdu_if.LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_len,
             vecs[i].name);
      m_hi = vecs[i].exp_hi;
      m_lo = vecs[i].exp_lo;
    end

    write_reg(3'd5, 32'h11, "hi_write");
    write_reg(3'd6, 32'h22, "lo_write");
    run_op(3'd3, 32'd100, 32'd0, 32'h11, 32'h22, 10, "div_by_zero");
    run_op(3'd4, 32'd100, 32'd0, 32'h11, 32'h22, 10, "divu_by_zero");

    // Start with a non-arithmetic op must do nothing, even a register write.
    run_op(3'd5, 32'hDEADBEEF, 32'd0, 32'h11, 32'h22, 0, "start_hiwrite_ignored");

`ifdef MDU_MADD_EN
    run_op(3'd7, 32'hFFFFFFFF, 32'd2, 32'h11, 32'h20, 5, "madd");
    m_lo = 32'h20;
`else
    run_op(3'd7, 32'hFFFFFFFF, 32'd2, 32'h11, 32'h22, 0, "op7_noop");
`endif

    // Second MULT and a HI write arrive while busy; both must be ignored.
    mdu_if.Start = 1'b1;
    mdu_if.MADop = 3'd1;
    mdu_if.RS_Data = 32'd3;
    mdu_if.RT_Data = 32'd4;
    @(negedge clk);
    mdu_if.Start = 1'b0;
    mdu_if.MADop = 3'd0;
    len = 0;
    for (int i = 0; i < 40 && mdu_if.Busy; i++) begin
      len++;
      if (i == 1) begin
        mdu_if.Start = 1'b1;
        mdu_if.MADop = 3'd1;
        mdu_if.RS_Data = 32'd100;
        mdu_if.RT_Data = 32'd100;
      end else if (i == 2) begin
        mdu_if.Start = 1'b0;
        mdu_if.MADop = 3'd5;
        mdu_if.RS_Data = 32'hDEADBEEF;
      end else begin
        mdu_if.Start = 1'b0;
        mdu_if.MADop = 3'd0;
      end
      @(negedge clk);
    end
    mdu_if.Start = 1'b0;
    mdu_if.MADop = 3'd0;
    check("busy_restart_len", 32'(len), 32'd5);
    check("busy_restart_hi", mdu_if.HI, 32'd0);
    check("busy_restart_lo", mdu_if.LO, 32'd12);
    $display("[TB] start_during_busy busy=%0d hi=%08h lo=%08h", len, mdu_if.HI, mdu_if.LO);
    m_hi = 32'd0;
    m_lo = 32'd12;
    @(negedge clk);
    check("no_second_commit_lo", mdu_if.LO, 32'd12);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(1, 7));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (op == 3'd5 || op == 3'd6) begin
        write_reg(op, rs, $sformatf("rand%0d_write", n));
      end else begin
        model_op(op, rs, rt, m_hi, m_lo, cyc);
        run_op(op, rs, rt, m_hi, m_lo, cyc, $sformatf("rand%0d", n));
      end
    end

    // Reset two cycles into a MULT clears everything at once and nothing commits later.
    write_reg(3'd5, 32'h55, "pre_reset_hi");
    write_reg(3'd6, 32'h66, "pre_reset_lo");
    mdu_if.Start = 1'b1;
    mdu_if.MADop = 3'd1;
    mdu_if.RS_Data = 32'd7;
    mdu_if.RT_Data = 32'd9;
    @(negedge clk);
    mdu_if.Start = 1'b0;
    mdu_if.MADop = 3'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(mdu_if.Busy), 32'd0);
    check("async_reset_hi", mdu_if.HI, 32'd0);
    check("async_reset_lo", mdu_if.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_reset_busy", 32'(mdu_if.Busy), 32'd0);
    check("post_reset_hi", mdu_if.HI, 32'd0);
    check("post_reset_lo", mdu_if.LO, 32'd0);
    $display("[TB] reset_mid_op busy=%0d hi=%08h lo=%08h", mdu_if.Busy, mdu_if.HI, mdu_if.LO);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline, with its own HI/LO register pair.
- Consumes the decoder's Start, MADop and HILO-class signals, plus forwarded rs/rt operand values.
- Produces Busy for the D-stage stall logic, and HI/LO values for mfhi/mflo result selection.
- Models the multi-cycle latency of mult/multu (5 cycles) and div/divu (10 cycles).

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1).
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  E-stage instruction is mult/multu/div/divu.
- MADop  input  3  operation code; encodings defined in the shared package.
- RS_Data  input  32  forwarded rs value (E stage).
- RT_Data  input  32  forwarded rt value (E stage).
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- MADop encodings: MAD_Default=0, MULT=1, MULTU=2, DIV=3, DIVU=4, HI_Write=5, LO_Write=6; 7 is reserved (see Optional Feature).
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, Busy=0, counter=0.
  - Pending results are discarded.
- States: IDLE (counter==0) and RUN (counter>0). Busy = (counter != 0), driven directly from the register.
- IDLE with Start=1 at edge k:
  - Latch the operation and compute the pending results into internal pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Busy is high from edge k through edge k+N, i.e. exactly N cycles after the Start cycle.
- RUN: counter decrements each edge. On the edge where counter goes 1→0, HI←pend_hi and LO←pend_lo, and Busy falls.
  - New values are visible on HI/LO in the first cycle Busy=0.
- Arithmetic:
  - MULT: signed 32×32→64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32×32→64; HI=[63:32], LO=[31:0].
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned; LO=quotient, HI=remainder.
- Divide by zero: Busy behaves normally for DIV_CYCLES, and HI/LO stay unchanged at commit.
- HI_Write/LO_Write (Start=0): HI or LO ← RS_Data at the next edge, no latency, Busy stays 0.
- Start or HI_Write/LO_Write while Busy=1: ignored, with no effect on the counter, pending results or HI/LO. The stall logic guarantees this never happens legally.
- Start=1 together with MADop not in {MULT..DIVU}: ignored.
- The stall logic stalls any HILO-class instruction in D while (Busy || Start). The unit does no checking of that itself.

Optional Feature:
- Macro MDU_MADD_EN.
  - Defined: MADop=7 (MADD) is a multiply-class operation. {HI,LO} ← {HI,LO} + signed(RS_Data)×signed(RT_Data), mod 2^64. The addend is the {HI,LO} value at the Start edge, and the operation takes MULT_CYCLES.
  - Not defined: MADop=7 is treated as MAD_Default, with no effect.

Decomposition:
- Shared package/header: MADop encodings, and the default MULT_CYCLES/DIV_CYCLES values, so the decoder and this unit agree.
- One sub-module, mdu_arith: combinational, computes {pend_hi, pend_lo} from the op and operands, including signed/unsigned and divide-by-zero handling.
- The parent holds the counter, the FSM and the HI/LO registers.

Test Plan:
- Reset mid-op: MULT started, reset asserted at cycle 2 → Busy=0 and HI=LO=0 immediately, asynchronously; no commit afterwards.
- MULT, RS=0xFFFFFFFD, RT=5 → Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIV, RS=0xFFFFFFF9 (−7), RT=2 → Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, 7/2 → LO=3, HI=1.
- Pre-load HI=0x11, LO=0x22 via HI_Write/LO_Write, then DIV by RT=0 → Busy for 10 cycles, HI/LO remain 0x11/0x22.
- Start during Busy: second MULT issued mid-run → it is ignored; first result commits on schedule; Busy pulse length stays 5.
